// File: rtl/mips_muldiv_pkg.sv
// Shared types for the MIPS multiply/divide sequencer: command codes, FSM states, magnitude helper.
package mips_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MFHI  = 3'd4,
    OP_MFLO  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mips_muldiv_dp.sv
// Mul/div datapath: 64-bit iteration register, shift-add / restoring-divide step and sign fix.
// Load and step strobes come from the sequencer FSM; o_hi/o_lo are valid in the FIX cycle.
module mips_muldiv_dp
  import mips_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_is_div,
  input  logic        i_signed,
  input  logic        i_div_zero,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [31:0] r_acc;
  logic [31:0] r_low;
  logic [31:0] r_opnd;
  logic        r_neg_a;
  logic        r_neg_b;
  logic        r_is_div;

  logic        w_neg_rs, w_neg_rt;
  logic [31:0] w_mag_rs, w_mag_rt;
  logic [32:0] w_sum;
  logic [32:0] w_shl;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_prod;

  assign w_neg_rs = i_signed & i_rs[31];
  assign w_neg_rt = i_signed & i_rt[31];
  assign w_mag_rs = mag32(i_rs, w_neg_rs);
  assign w_mag_rt = mag32(i_rt, w_neg_rt);

  assign w_sum  = {1'b0, r_acc} + (r_low[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_shl  = {r_acc, r_low[31]};
  assign w_ge   = (w_shl >= {1'b0, r_opnd});
  // When w_ge holds the true difference is below the divisor, so 32 bits suffice.
  assign w_diff = w_shl[31:0] - r_opnd;
  assign w_prod = {r_acc, r_low};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_low    <= '0;
      r_opnd   <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_is_div <= 1'b0;
    end else if (i_load) begin
      r_is_div <= i_is_div;
      if (i_div_zero) begin
        // Preload the architectural divide-by-zero result; FIX passes it through unchanged.
        r_acc   <= i_rs;
        r_low   <= 32'hFFFF_FFFF;
        r_opnd  <= '0;
        r_neg_a <= 1'b0;
        r_neg_b <= 1'b0;
      end else begin
        r_acc   <= '0;
        r_low   <= i_is_div ? w_mag_rs : w_mag_rt;
        r_opnd  <= i_is_div ? w_mag_rt : w_mag_rs;
        r_neg_a <= w_neg_rs;
        r_neg_b <= w_neg_rt;
      end
    end else if (i_step) begin
      if (r_is_div) begin
        r_acc <= w_ge ? w_diff : w_shl[31:0];
        r_low <= {r_low[30:0], w_ge};
      end else begin
        r_acc <= w_sum[32:1];
        r_low <= {w_sum[0], r_low[31:1]};
      end
    end
  end

  always_comb begin
    o_hi = r_acc;
    o_lo = r_low;
    if (r_is_div) begin
      o_lo = (r_neg_a ^ r_neg_b) ? (~r_low + 32'd1) : r_low;
      o_hi = r_neg_a ? (~r_acc + 32'd1) : r_acc;
    end else if (r_neg_a ^ r_neg_b) begin
      {o_hi, o_lo} = ~w_prod + 64'd1;
    end
  end

endmodule

// File: rtl/mips_muldiv_seq.sv
// MIPS mul/div sequencer: owns HI/LO, 32-iteration MULT/DIV (33 busy cycles, 1 for divide by zero).
// While busy md_ready is low and further mul/div commands are held by decode under md_stall.
module mips_muldiv_seq
  import mips_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            md_valid,
  input  md_op_t          md_op,
  input  logic [XLEN-1:0] md_rs_data,
  input  logic [XLEN-1:0] md_rt_data,
  output logic            md_ready,
  output logic            md_busy,
  output logic            md_stall,
  output logic [XLEN-1:0] md_result,
  output logic            md_result_valid,
  output logic            md_div_zero
);

  md_state_t       r_state, w_next;
  logic [4:0]      r_cnt;
  logic [XLEN-1:0] r_hi, r_lo;
  logic            r_dz;

  logic            w_accept, w_start, w_is_div, w_rt_zero;
  logic            w_load, w_step;
  logic [31:0]     w_dp_hi, w_dp_lo;

  assign w_accept  = md_valid & md_ready;
  assign w_start   = w_accept & (md_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
  assign w_is_div  = (md_op == OP_DIV) || (md_op == OP_DIVU);
  assign w_rt_zero = (md_rt_data == '0);

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_load = 1'b1;
          w_next = (w_is_div && w_rt_zero) ? ST_FIX : ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_cnt == 5'd0) w_next = ST_FIX;
      end
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign md_ready        = (r_state == ST_IDLE);
  assign md_busy         = ~md_ready;
  assign md_stall        = md_valid & ~md_ready;
  assign md_result       = (md_op == OP_MFHI) ? r_hi : r_lo;
  assign md_result_valid = w_accept & ((md_op == OP_MFHI) || (md_op == OP_MFLO));
  assign md_div_zero     = (r_state == ST_FIX) & r_dz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 5'd0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_cnt <= 5'd31;
        r_dz  <= w_is_div & w_rt_zero;
      end else if (w_step && r_cnt != 5'd0) begin
        r_cnt <= r_cnt - 5'd1;
      end
      if (r_state == ST_FIX) begin
        r_hi <= w_dp_hi;
        r_lo <= w_dp_lo;
      end else if (w_accept && md_op == OP_MTHI) begin
        r_hi <= md_rs_data;
      end else if (w_accept && md_op == OP_MTLO) begin
        r_lo <= md_rs_data;
      end
    end
  end

  mips_muldiv_dp u_dp (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_is_div   (w_is_div),
    .i_signed   ((md_op == OP_MULT) || (md_op == OP_DIV)),
    .i_div_zero (w_is_div & w_rt_zero),
    .i_rs       (md_rs_data),
    .i_rt       (md_rt_data),
    .o_hi       (w_dp_hi),
    .o_lo       (w_dp_lo)
  );

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Randomized self-checking bench for mips_muldiv_seq against an arithmetic HI/LO reference model.
module tb_mips_muldiv_seq;
  import mips_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_valid;
  md_op_t      md_op;
  logic [31:0] md_rs_data, md_rt_data;
  logic        md_ready, md_busy, md_stall, md_result_valid, md_div_zero;
  logic [31:0] md_result;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi, m_lo;
  logic [31:0] obs_hi, obs_lo;

  always #5 clk = ~clk;

  mips_muldiv_seq dut (
    .clk             (clk),
    .rst             (rst),
    .md_valid        (md_valid),
    .md_op           (md_op),
    .md_rs_data      (md_rs_data),
    .md_rt_data      (md_rt_data),
    .md_ready        (md_ready),
    .md_busy         (md_busy),
    .md_stall        (md_stall),
    .md_result       (md_result),
    .md_result_valid (md_result_valid),
    .md_div_zero     (md_div_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {HI, LO} after the given op, from plain signed/unsigned arithmetic.
  function automatic logic [63:0] ref_md(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  ref_md = 64'(sa * sb);
      OP_MULTU: ref_md = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 0) ref_md = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          ref_md = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU:  ref_md = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default:  ref_md = {m_hi, m_lo};
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       pick = 32'd0;
      1:       pick = 32'h8000_0000;
      2:       pick = 32'hFFFF_FFFF;
      3:       pick = 32'($urandom_range(0, 15));
      default: pick = $urandom;
    endcase
  endfunction

  task automatic read_hilo();
    @(negedge clk);
    md_valid = 1'b1;
    md_op    = OP_MFHI;
    #1;
    check("mfhi_valid", md_result_valid, 1);
    obs_hi = md_result;
    md_op  = OP_MFLO;
    #1;
    check("mflo_valid", md_result_valid, 1);
    obs_lo = md_result;
    @(negedge clk);
    md_valid = 1'b0;
    #1;
  endtask

  task automatic do_mt(input md_op_t op, input logic [31:0] a);
    @(negedge clk);
    md_valid   = 1'b1;
    md_op      = op;
    md_rs_data = a;
    #1;
    check("mt_ready", md_ready, 1);
    @(negedge clk);
    md_valid = 1'b0;
    #1;
    if (op == OP_MTHI) m_hi = a;
    else               m_lo = a;
  endtask

  task automatic do_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    logic        dz_case;
    int          cyc, dz;
    e       = ref_md(op, a, b);
    dz_case = (op == OP_DIV || op == OP_DIVU) && (b == 0);
    @(negedge clk);
    md_valid   = 1'b1;
    md_op      = op;
    md_rs_data = a;
    md_rt_data = b;
    #1;
    check("issue_ready", md_ready, 1);
    check("issue_stall", md_stall, 0);
    @(negedge clk);
    md_valid = 1'b0;
    #1;
    cyc = 0;
    dz  = 0;
    while (md_busy && cyc < 100) begin
      cyc++;
      dz += int'(md_div_zero);
      @(negedge clk);
      #1;
    end
    check("busy_cycles", 32'(cyc), dz_case ? 32'd1 : 32'd33);
    check("div_zero_cycles", 32'(dz), dz_case ? 32'd1 : 32'd0);
    m_hi = e[63:32];
    m_lo = e[31:0];
    read_hilo();
    check("hi", obs_hi, m_hi);
    check("lo", obs_lo, m_lo);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [63:0] e;
    int          n;
    md_op_t      rop;
    rst        = 1'b1;
    md_valid   = 1'b0;
    md_op      = OP_MFLO;
    md_rs_data = '0;
    md_rt_data = '0;
    m_hi       = '0;
    m_lo       = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", md_ready, 1);
    check("rst_busy", md_busy, 0);
    check("rst_div_zero", md_div_zero, 0);
    check("rst_stall", md_stall, 0);
    check("rst_result_valid", md_result_valid, 0);
    check("rst_result", md_result, 0);
    @(negedge clk);
    rst = 1'b0;

    read_hilo();
    check("mflo_after_reset", obs_lo, 32'h0);
    do_mt(OP_MTHI, 32'h1234_5678);
    read_hilo();
    check("mthi_readback", obs_hi, 32'h1234_5678);

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi", obs_hi, 32'hFFFF_FFFE);
    check("multu_max_lo", obs_lo, 32'h0000_0001);
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    check("mult_m3x7_hi", obs_hi, 32'hFFFF_FFFF);
    check("mult_m3x7_lo", obs_lo, 32'hFFFF_FFEB);
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    check("mult_min_hi", obs_hi, 32'h4000_0000);
    check("mult_min_lo", obs_lo, 32'h0);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2_lo", obs_lo, 32'hFFFF_FFFD);
    check("div_m7_2_hi", obs_hi, 32'hFFFF_FFFF);
    do_op(OP_DIVU, 32'd7, 32'd0);
    check("divu_zero_lo", obs_lo, 32'hFFFF_FFFF);
    check("divu_zero_hi", obs_hi, 32'd7);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_lo", obs_lo, 32'h8000_0000);
    check("div_ovf_hi", obs_hi, 32'h0);

    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) do_mt(($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO, $urandom);
      rop = md_op_t'($urandom_range(0, 3));
      do_op(rop, pick(), pick());
    end

    // MFHI held under stall from 5 cycles after a MULT is accepted.
    e = ref_md(OP_MULT, 32'hFFFF_FF00, 32'h0001_2345);
    @(negedge clk);
    md_valid   = 1'b1;
    md_op      = OP_MULT;
    md_rs_data = 32'hFFFF_FF00;
    md_rt_data = 32'h0001_2345;
    @(negedge clk);
    md_valid = 1'b0;
    repeat (4) @(negedge clk);
    md_valid = 1'b1;
    md_op    = OP_MFHI;
    #1;
    n = 0;
    while (md_stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", 32'(n), 32'd29);
    check("stall_result_valid", md_result_valid, 1);
    check("stall_result_hi", md_result, e[63:32]);
    @(negedge clk);
    md_valid = 1'b0;
    m_hi     = e[63:32];
    m_lo     = e[31:0];

    // Reset 10 cycles into a DIV aborts it and clears HI/LO.
    do_mt(OP_MTHI, 32'hA5A5_A5A5);
    do_mt(OP_MTLO, 32'h5A5A_5A5A);
    @(negedge clk);
    md_valid   = 1'b1;
    md_op      = OP_DIV;
    md_rs_data = 32'd1000;
    md_rt_data = 32'd3;
    @(negedge clk);
    md_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check("pre_rst_busy", md_busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", md_ready, 1);
    check("mid_rst_busy", md_busy, 0);
    check("mid_rst_lo", md_result, 32'h0);
    md_op = OP_MFHI;
    #1;
    check("mid_rst_hi", md_result, 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    m_hi = '0;
    m_lo = '0;
    read_hilo();
    check("post_rst_mflo", obs_lo, 32'h0);
    check("post_rst_mfhi", obs_hi, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
